// File: rtl/str_bcast.sv
// str_bcast: Avalon-ST packet broadcaster.
// One sink stream is copied into a per-channel FIFO for every channel in the
// active mask. Each channel has its own valid/stall handshake. The mask is
// frozen for the length of a packet, so every beat of a packet reaches the
// same channel set. in_ready comes from a register, so out_stall has no
// combinational path to it.
module str_bcast #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    output logic                     in_ready,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_sop,
    output logic [NUM_CH-1:0]        out_eop,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_stall,
    output logic [31:0]              pkt_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 2;
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   w_mask;
    logic [NUM_CH-1:0]   w_mask_nxt;
    logic                r_in_ready;
    logic                w_ready_nxt;
    logic [31:0]         r_pkt_cnt;
    logic                w_accept;
    logic [EW-1:0]       w_entry;

    // Per-channel FIFO storage and bookkeeping; entry layout is {sop, eop, data}
    logic [EW-1:0]       r_mem    [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr [NUM_CH];
    logic [AW-1:0]       r_rd_ptr [NUM_CH];
    logic [CW-1:0]       r_count  [NUM_CH];
    logic [CW-1:0]       w_count_nxt [NUM_CH];
    logic [NUM_CH-1:0]   r_valid;
    logic [NUM_CH-1:0]   w_push;
    logic [NUM_CH-1:0]   w_pop;
    logic [NUM_CH-1:0]   w_full_nxt;
    logic [NUM_CH-1:0]   w_nempty_nxt;

    assign w_accept  = in_valid & r_in_ready;
    assign w_entry   = {in_sop, in_eop, in_data};
    assign in_ready  = r_in_ready;
    assign pkt_cnt   = r_pkt_cnt;
    assign out_valid = r_valid;

    // Effective mask: live ch_en while idle (so an sop beat uses it at once), frozen mask inside a packet
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_mask = ch_en;
        end else begin
            w_mask = r_mask;
        end
    end

    // Packet FSM next-state: sop without eop opens a packet, eop closes it, stray sop is ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && in_sop && !in_eop) begin
                    w_state_nxt = ST_IN_PKT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IN_PKT: begin
                if (w_accept && in_eop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_IN_PKT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Push/pop strobes; the not-full guard only protects against an idle-time ch_en change
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_push[i] = w_accept & w_mask[i] & (r_count[i] != C_FULL);
            w_pop[i]  = r_valid[i] & ~out_stall[i];
        end
    end

    // Next occupancy per channel, plus the full/non-empty flags derived from it
    always_comb begin
        w_full_nxt   = '0;
        w_nempty_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_count_nxt[i]  = r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            w_full_nxt[i]   = (w_count_nxt[i] == C_FULL);
            w_nempty_nxt[i] = (w_count_nxt[i] != {CW{1'b0}});
        end
    end

    // Mask that will apply next cycle: the frozen set if a packet stays open, otherwise ch_en
    always_comb begin
        if (w_state_nxt == ST_IN_PKT) begin
            w_mask_nxt = w_mask;
        end else begin
            w_mask_nxt = ch_en;
        end
        w_ready_nxt = ~|(w_full_nxt & w_mask_nxt);
    end

    // FSM state, active mask, registered in_ready and packet counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_in_ready <= 1'b0;
            r_pkt_cnt  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask;
            r_in_ready <= w_ready_nxt;
            if (w_accept && in_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    // FIFO pointers, occupancy and registered valid flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
                end
                r_count[i] <= w_count_nxt[i];
            end
            r_valid <= w_nempty_nxt;
        end
    end

    // FIFO storage write; contents need no reset because outputs are gated by valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_entry;
            end
        end
    end

    // Head entry onto the output bus, forced to zero for empty channels
    always_comb begin
        out_data = '0;
        out_sop  = '0;
        out_eop  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_valid[i]) begin
                out_data[i*DATA_W +: DATA_W] = r_mem[i][r_rd_ptr[i]][DATA_W-1:0];
                out_sop[i]                   = r_mem[i][r_rd_ptr[i]][DATA_W+1];
                out_eop[i]                   = r_mem[i][r_rd_ptr[i]][DATA_W];
            end else begin
                out_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                out_sop[i]                   = 1'b0;
                out_eop[i]                   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_str_bcast.sv
// Directed testbench for str_bcast (DATA_W=8, NUM_CH=2, FIFO_DEPTH=4).
module tb_str_bcast;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int FD = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_sop;
    logic             in_eop;
    logic             in_ready;
    logic [NC-1:0]    ch_en;
    logic [NC*DW-1:0] out_data;
    logic [NC-1:0]    out_sop;
    logic [NC-1:0]    out_eop;
    logic [NC-1:0]    out_valid;
    logic [NC-1:0]    out_stall;
    logic [31:0]      pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    str_bcast #(.DATA_W(DW), .NUM_CH(NC), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_valid (out_valid),
        .out_stall (out_stall),
        .pkt_cnt   (pkt_cnt)
    );

    // Drive one beat from a negedge, wait (bounded) for in_ready, return at the negedge after acceptance.
    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        int w;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 2'b00 || pkt_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b pkt_cnt=%0d required 0/00/0", in_ready, out_valid, pkt_cnt);
        end
        n_tests++;
        if (out_data !== 16'h0000 || out_sop !== 2'b00 || out_eop !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data: data=%h sop=%b eop=%b required 0", out_data, out_sop, out_eop);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/00", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] e;
        logic s;
        logic f;
        do_reset();
        ch_en     = 2'b11;
        out_stall = 2'b00;
        for (int k = 0; k < 4; k++) begin
            e = 8'h41 + 8'(k);
            s = (k == 0);
            f = (k == 3);
            in_data = e; in_sop = s; in_eop = f; in_valid = 1'b1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_ready: beat %0d in_ready=%b required 1", k, in_ready);
            end
            @(negedge clk);
            n_tests++;
            if (out_valid !== 2'b11 || out_data !== {e, e} || out_sop !== {s, s} || out_eop !== {f, f}) begin
                n_fail++;
                $display("FAIL basic_beat: beat %0d valid=%b data=%h sop=%b eop=%b required 11 %h%h %b%b %b%b",
                         k, out_valid, out_data, out_sop, out_eop, e, e, s, s, f, f);
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 2'b00 || pkt_cnt !== 32'd1 || dut.r_state !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: valid=%b pkt_cnt=%0d state=%b required 00/1/0", out_valid, pkt_cnt, dut.r_state);
        end
    endtask

    task automatic test_stall();
        logic [7:0] e;
        logic acc;
        int sent;
        int got0;
        int got1;
        int cyc;
        do_reset();
        ch_en     = 2'b11;
        out_stall = 2'b10;
        sent = 0; got0 = 0; got1 = 0; cyc = 0;
        while ((got0 < 6 || got1 < 6) && cyc < 80) begin
            if (cyc == 12) out_stall = 2'b00;
            if (sent < 6) begin
                in_valid = 1'b1;
                in_data  = 8'h10 + 8'(sent);
                in_sop   = (sent == 0);
                in_eop   = (sent == 5);
            end else begin
                in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            end
            if (out_stall[1] && sent >= 4) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_ready: cyc %0d in_ready=%b required 0", cyc, in_ready);
                end
            end
            if (out_valid[0]) begin
                e = 8'h10 + 8'(got0);
                n_tests++;
                if (out_data[7:0] !== e || out_sop[0] !== (got0 == 0) || out_eop[0] !== (got0 == 5)) begin
                    n_fail++;
                    $display("FAIL stall_ch0: idx %0d data=%h sop=%b eop=%b required %h", got0, out_data[7:0], out_sop[0], out_eop[0], e);
                end
                got0++;
            end
            if (out_valid[1]) begin
                e = 8'h10 + 8'(got1);
                n_tests++;
                if (out_data[15:8] !== e || out_sop[1] !== (got1 == 0) || out_eop[1] !== (got1 == 5)) begin
                    n_fail++;
                    $display("FAIL stall_ch1: idx %0d data=%h sop=%b eop=%b required %h", got1, out_data[15:8], out_sop[1], out_eop[1], e);
                end
                if (!out_stall[1]) got1++;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        n_tests++;
        if (sent != 6 || got0 != 6 || got1 != 6) begin
            n_fail++;
            $display("FAIL stall_complete: sent=%0d ch0=%0d ch1=%0d required 6/6/6", sent, got0, got1);
        end
    endtask

    task automatic test_mask_change();
        do_reset();
        ch_en     = 2'b11;
        out_stall = 2'b00;
        send_beat(8'h20, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 2'b11 || out_data !== 16'h2020) begin
            n_fail++;
            $display("FAIL mask_b0: valid=%b data=%h required 11 2020", out_valid, out_data);
        end
        ch_en = 2'b01;
        send_beat(8'h21, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 2'b11 || out_data !== 16'h2121) begin
            n_fail++;
            $display("FAIL mask_b1: valid=%b data=%h required 11 2121", out_valid, out_data);
        end
        send_beat(8'h22, 1'b0, 1'b1);
        n_tests++;
        if (out_valid !== 2'b11 || out_data !== 16'h2222 || out_eop !== 2'b11) begin
            n_fail++;
            $display("FAIL mask_b2: valid=%b data=%h eop=%b required 11 2222 11", out_valid, out_data, out_eop);
        end
        send_beat(8'h30, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 2'b01 || out_data !== 16'h0030) begin
            n_fail++;
            $display("FAIL mask_p2b0: valid=%b data=%h required 01 0030", out_valid, out_data);
        end
        send_beat(8'h31, 1'b0, 1'b1);
        n_tests++;
        if (out_valid !== 2'b01 || out_data !== 16'h0031) begin
            n_fail++;
            $display("FAIL mask_p2b1: valid=%b data=%h required 01 0031", out_valid, out_data);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 2'b00 || pkt_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL mask_end: valid=%b pkt_cnt=%0d required 00/2", out_valid, pkt_cnt);
        end
    endtask

    task automatic test_mask_zero();
        do_reset();
        ch_en     = 2'b00;
        out_stall = 2'b00;
        for (int k = 0; k < 3; k++) begin
            send_beat(8'h60 + 8'(k), 1'b1, 1'b1);
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_mask: pkt %0d in_ready=%b valid=%b required 1/00", k, in_ready, out_valid);
            end
        end
        n_tests++;
        if (pkt_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL zero_cnt: pkt_cnt=%0d required 3", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ch_en     = 2'b11;
        out_stall = 2'b11;
        send_beat(8'h4F, 1'b1, 1'b1);
        send_beat(8'h50, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 2'b11 || out_data !== 16'h4F4F || pkt_cnt !== 32'd1 || dut.r_state !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: valid=%b data=%h pkt_cnt=%0d state=%b required 11 4f4f 1 1",
                     out_valid, out_data, pkt_cnt, dut.r_state);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_tests++;
        if (out_valid !== 2'b00 || pkt_cnt !== 32'd0 || dut.r_state !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_post: valid=%b pkt_cnt=%0d state=%b in_ready=%b required 00 0 0 0",
                     out_valid, pkt_cnt, dut.r_state, in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_ready: in_ready=%b valid=%b required 1/00", in_ready, out_valid);
        end
        out_stall = 2'b00;
    endtask

    task automatic test_wrap();
        do_reset();
        ch_en = 2'b00;
        force dut.r_pkt_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_pkt_cnt;
        n_tests++;
        if (pkt_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_pre: pkt_cnt=%h required ffffffff", pkt_cnt);
        end
        send_beat(8'h70, 1'b1, 1'b1);
        n_tests++;
        if (pkt_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_post: pkt_cnt=%h required 00000000", pkt_cnt);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        ch_en     = 2'b00;
        out_stall = 2'b00;
        test_reset();
        test_basic();
        test_stall();
        test_mask_change();
        test_mask_zero();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/str_bcast.md
STR_BCAST -- requirements
Module: str_bcast

Interface
REQ-001 SHALL have parameter DATA_W, default 8: symbol width in bits.
REQ-002 SHALL have parameter NUM_CH, default 2, range 1..16: number of consumer channels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of 2, >=2: per-channel buffer entries.
REQ-004 SHALL have port clk, input, 1: the block's one clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port in_data, input, DATA_W: Avalon-ST sink symbol.
REQ-007 SHALL have port in_valid, input, 1: sink beat valid.
REQ-008 SHALL have port in_sop, input, 1: sink start-of-packet.
REQ-009 SHALL have port in_eop, input, 1: sink end-of-packet.
REQ-010 SHALL have port in_ready, output, 1: sink ready, zero ready latency.
REQ-011 SHALL have port ch_en, input, NUM_CH: requested channel enable mask.
REQ-012 SHALL have port out_data, output, NUM_CH*DATA_W: per-channel symbol, channel i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port out_sop, output, NUM_CH: per-channel start-of-packet.
REQ-014 SHALL have port out_eop, output, NUM_CH: per-channel end-of-packet.
REQ-015 SHALL have port out_valid, output, NUM_CH: per-channel valid, HLS call style.
REQ-016 SHALL have port out_stall, input, NUM_CH: per-channel consumer stall, active-high.
REQ-017 SHALL have port pkt_cnt, output, 32: count of accepted end-of-packet beats.

Function
REQ-018 SHALL give every channel its own FIFO of FIFO_DEPTH entries holding {sop, eop, data}.
REQ-019 SHALL accept a sink beat when in_valid && in_ready and SHALL then push it into the FIFO of every channel set in the active mask.
REQ-020 SHALL drive in_ready = 1 only when no FIFO selected by the active mask is full.
REQ-021 SHALL register in_ready from FIFO occupancy: no combinational path from out_stall to in_ready.
REQ-022 SHALL not treat a pop in the same cycle as freeing space for that cycle's push.
REQ-023 SHALL drive out_valid[i] = 1 whenever FIFO i is non-empty, showing the head entry on out_data/out_sop/out_eop.
REQ-024 SHALL pop FIFO i when out_valid[i] && !out_stall[i].
REQ-025 SHALL hold the head entry stable while out_stall[i] is 1.
REQ-026 SHALL present a beat accepted in cycle N on an empty, unstalled channel with out_valid high in cycle N+1.
REQ-027 SHALL run a two-state packet FSM with states IDLE and IN_PKT.
REQ-028 SHALL move IDLE->IN_PKT on an accepted beat with in_sop=1 and in_eop=0.
REQ-029 SHALL move IN_PKT->IDLE on an accepted beat with in_eop=1.
REQ-030 SHALL stay in IDLE on an accepted beat with in_sop=1 and in_eop=1 (single-beat packet).
REQ-031 SHALL load the active mask from ch_en in IDLE.
REQ-032 SHALL freeze the active mask while in IN_PKT, so a packet always reaches the same channel set.
REQ-033 SHALL use the mask loaded in the same cycle for an sop beat accepted from IDLE.
REQ-034 SHALL, if the active mask is all zero, hold in_ready = 1 and discard accepted beats; FSM and pkt_cnt still update.
REQ-035 SHALL forward beats without sop/eop framing checks; a stray sop inside IN_PKT is passed through and does not change state.
REQ-036 SHALL increment pkt_cnt by 1 on each accepted beat with in_eop=1, wrapping 0xFFFFFFFF->0.
REQ-037 SHALL keep a full FIFO from limiting in_ready if its channel is disabled.

Reset
REQ-038 SHALL, while reset_n=0 at a rising edge, empty all FIFOs and set FSM=IDLE, active mask=0, pkt_cnt=0, in_ready=0, out_valid=0.
REQ-039 SHALL reset to out_data=0, out_sop=0, out_eop=0.
REQ-040 SHALL, on reset mid-packet, discard all buffered beats with no partial-packet flush.
REQ-041 SHALL assert in_ready (subject to REQ-020) from the first cycle after reset_n returns to 1.

Verification
REQ-042 SHALL cover: NUM_CH=2, ch_en=2'b11, no stall, 4-beat packet 0x41..0x44 -> both channels out 0x41..0x44 one cycle after each accept; sop on first beat, eop on last; pkt_cnt=1.
REQ-043 SHALL cover: out_stall[1]=1 held, 6 beats streamed -> ch1 holds 4 beats; in_ready=0 after the 4th accept; ch0 drains; release stall -> in_ready returns, all 6 beats arrive in order on both channels.
REQ-044 SHALL cover: ch_en changes 11->01 mid-packet -> packet completes on both channels; next packet reaches ch0 only; ch1 out_valid stays 0.
REQ-045 SHALL cover: ch_en=0, 3 single-beat packets -> in_ready=1 throughout; all out_valid=0; pkt_cnt=3.
REQ-046 SHALL cover: reset_n=0 for 1 cycle with 2 beats buffered -> next cycle out_valid=0, pkt_cnt=0, FSM=IDLE.
REQ-047 SHALL cover: pkt_cnt forced to 0xFFFFFFFF, then one eop accepted -> pkt_cnt=0.
